// File: rtl/usb_fs_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : usb_fs_rr_arb
//  Description : Endpoint request arbiter. Grants one requesting endpoint at
//                a time and holds the grant while the winner keeps its request
//                high. The next winner is chosen either round-robin, scanning
//                upward from the previous winner, or by fixed priority, where
//                the lowest index wins. An optional hold limit hands the grant
//                on after MAX_HOLD cycles when another endpoint is waiting.
//  Ports       : clk         - single clock, rising edge
//                reset       - synchronous, active-high
//                ep_req      - per-endpoint request [NUM_EPS]
//                ep_grant    - registered one-hot (or zero) grant [NUM_EPS]
//                grant_valid - registered, high whenever ep_grant is non-zero
//                grant_idx   - registered index of the granted endpoint,
//                              0 while grant_valid is low
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_fs_rr_arb #(
    parameter int NUM_EPS    = 4,
    parameter int FIXED_PRIO = 0,
    parameter int MAX_HOLD   = 0,
    localparam int IDX_W     = $clog2(NUM_EPS > 1 ? NUM_EPS : 2)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_EPS-1:0] ep_req,
    output logic [NUM_EPS-1:0] ep_grant,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx
);

    localparam int                HC_W     = $clog2(MAX_HOLD > 1 ? MAX_HOLD : 2);
    localparam logic [HC_W-1:0]   HOLD_LIM = HC_W'(MAX_HOLD > 0 ? MAX_HOLD - 1 : 0);
    // Resetting the "previous winner" to the top index makes EP0 win first.
    localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(NUM_EPS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   last_idx;
    logic [IDX_W-1:0]   last_nxt;
    logic [IDX_W-1:0]   idx_nxt;
    logic [HC_W-1:0]    hold_cnt;
    logic [HC_W-1:0]    hold_nxt;
    logic [NUM_EPS-1:0] grant_nxt;
    logic [NUM_EPS-1:0] others;
    logic               hold_evt;
    int                 scan_start;

    // First set bit of cand at or above start; wraps to the lowest set bit.
    function automatic logic [IDX_W-1:0] pick(input logic [NUM_EPS-1:0] cand,
                                              input int                 start);
        logic [IDX_W-1:0] hi;
        logic [IDX_W-1:0] lo;
        logic             hi_found;
        hi       = '0;
        lo       = '0;
        hi_found = 1'b0;
        // Walking downward leaves the lowest qualifying index in hi/lo.
        for (int i = NUM_EPS - 1; i >= 0; i--) begin
            if (cand[i]) begin
                lo = IDX_W'(i);
                if (i >= start) begin
                    hi       = IDX_W'(i);
                    hi_found = 1'b1;
                end
            end
        end
        return hi_found ? hi : lo;
    endfunction

    // Requesters other than the current holder.
    assign others = ep_req & ~ep_grant;

    generate
        if (MAX_HOLD > 0) begin : g_hold_limit
            assign hold_evt = (hold_cnt == HOLD_LIM) && (|others);
        end else begin : g_no_hold_limit
            assign hold_evt = 1'b0;
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        idx_nxt   = grant_idx;
        last_nxt  = last_idx;
        hold_nxt  = hold_cnt;

        if (FIXED_PRIO != 0) begin
            scan_start = 0;
        end else if (int'(last_idx) >= NUM_EPS - 1) begin
            scan_start = 0;
        end else begin
            scan_start = int'(last_idx) + 1;
        end

        case (state)
            IDLE: begin
                if (|ep_req) begin
                    state_nxt = BUSY;
                    idx_nxt   = pick(ep_req, scan_start);
                    last_nxt  = idx_nxt;
                    hold_nxt  = '0;
                end
            end
            BUSY: begin
                if (!ep_req[grant_idx]) begin
                    // Holder released: its bit is already clear in ep_req, so
                    // the grant passes straight to the next winner, no gap.
                    if (|ep_req) begin
                        idx_nxt  = pick(ep_req, scan_start);
                        last_nxt = idx_nxt;
                        hold_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                        hold_nxt  = '0;
                    end
                end else if (hold_evt) begin
                    idx_nxt  = pick(others, scan_start);
                    last_nxt = idx_nxt;
                    hold_nxt = '0;
                end else if (hold_cnt != HOLD_LIM) begin
                    hold_nxt = hold_cnt + HC_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
                hold_nxt  = '0;
            end
        endcase

        grant_nxt = (state_nxt == BUSY) ? (NUM_EPS'(1) << idx_nxt) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ep_grant    <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            hold_cnt    <= '0;
            last_idx    <= LAST_RST;
        end else begin
            state       <= state_nxt;
            ep_grant    <= grant_nxt;
            grant_valid <= (state_nxt == BUSY);
            grant_idx   <= idx_nxt;
            hold_cnt    <= hold_nxt;
            last_idx    <= last_nxt;
        end
    end

endmodule
`default_nettype wire
